// File: rtl/priority_arbiter.sv
// priority_arbiter: shares one resource among NUM_REQ requesters, highest index wins,
// fixed or round-robin selection, grant held until release or hold timeout.
module priority_arbiter #(
    parameter int NUM_REQ  = 8,
    parameter int ID_W     = $clog2(NUM_REQ),
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               rr_en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid,
    output logic               timeout
);
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1} state_t;
    state_t          state;
    logic [HW-1:0]   hold_cnt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] idx;
    int              t;
    logic            release_now;
    always_comb begin
        win = '0;
        idx = '0;
        t   = 0;
        if (rr_en) begin
            // Walk from farthest to nearest so the first hit below rr_ptr (with wrap) is kept last.
            for (int d = NUM_REQ - 1; d >= 0; d--) begin
                t = int'(rr_ptr) - d;
                if (t < 0) t = t + NUM_REQ;
                idx = ID_W'(t);
                if (req[idx]) win = idx;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                idx = ID_W'(i);
                if (req[idx]) win = idx;
            end
        end
    end
    assign release_now = !req[gnt_id] || (MAX_HOLD != 0 && hold_cnt == HW'(MAX_HOLD));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            rr_ptr    <= ID_W'(NUM_REQ - 1);
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (state == GRANT) begin
                if (release_now) begin
                    state     <= IDLE;
                    hold_cnt  <= '0;
                    gnt       <= '0;
                    gnt_id    <= '0;
                    gnt_valid <= 1'b0;
                    timeout   <= req[gnt_id];
                end else if (MAX_HOLD != 0) begin
                    hold_cnt <= hold_cnt + HW'(1);
                end
            end else if (|req) begin
                state     <= GRANT;
                hold_cnt  <= HW'(1);
                gnt       <= NUM_REQ'(1) << win;
                gnt_id    <= win;
                gnt_valid <= 1'b1;
                rr_ptr    <= (win == '0) ? ID_W'(NUM_REQ - 1) : win - ID_W'(1);
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_priority_arbiter.sv
// tb_priority_arbiter: directed checks of priority_arbiter (8 requesters, hold limit 16).
module tb_priority_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       rr_en;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;
    int         checks = 0;
    int         errors = 0;

    priority_arbiter #(.NUM_REQ(8), .MAX_HOLD(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .rr_en(rr_en),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_g(input string tag, input int id);
        logic [7:0] one_hot;
        one_hot = 8'd1 << id;
        chk({tag, "_valid"}, {31'd0, gnt_valid}, 32'd1);
        chk({tag, "_id"}, {29'd0, gnt_id}, id);
        chk({tag, "_gnt"}, {24'd0, gnt}, {24'd0, one_hot});
        chk({tag, "_to"}, {31'd0, timeout}, 32'd0);
    endtask

    task automatic chk_idle(input string tag, input logic exp_to);
        chk({tag, "_valid"}, {31'd0, gnt_valid}, 32'd0);
        chk({tag, "_gnt"}, {24'd0, gnt}, 32'd0);
        chk({tag, "_to"}, {31'd0, timeout}, {31'd0, exp_to});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        req   = '0;
        rr_en = 1'b0;
        do_reset();
        chk_idle("reset", 1'b0);
        chk("reset_id", {29'd0, gnt_id}, 32'd0);

        // fixed priority
        req = 8'b0010_0110;
        tick();
        chk_g("fixed", 5);

        // no preemption, then one idle gap before 7 takes over
        req = 8'b1010_0110;
        tick();
        chk_g("nopre1", 5);
        tick();
        chk_g("nopre2", 5);
        req = 8'b1000_0110;
        tick();
        chk_idle("gap", 1'b0);
        tick();
        chk_g("next7", 7);
        req = '0;
        tick();
        chk_idle("rel7", 1'b0);

        // round robin from a fresh pointer
        do_reset();
        rr_en = 1'b1;
        req   = 8'hFF;
        tick();
        for (int i = 0; i < 9; i++) begin
            chk_g("rr", (i == 8) ? 7 : 7 - i);
            tick();
            chk_g("rr_hold", (i == 8) ? 7 : 7 - i);
            req = 8'hFF & ~(8'd1 << ((i == 8) ? 7 : 7 - i));
            tick();
            chk_idle("rr_gap", 1'b0);
            req = 8'hFF;
            tick();
        end
        req = '0;
        tick();
        chk_idle("rr_end", 1'b0);

        // hold timeout
        rr_en = 1'b0;
        req   = 8'h08;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk_g("hold", 3);
        end
        tick();
        chk_idle("timeout", 1'b1);
        tick();
        chk_g("regrant", 3);
        req = '0;
        tick();
        chk_idle("rel3", 1'b0);

        // async reset mid-grant
        req = 8'h10;
        tick();
        chk_g("own4", 4);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("async_rst", 1'b0);
        chk("async_id", {29'd0, gnt_id}, 32'd0);
        tick();
        rst_n = 1'b1;
        req   = 8'h81;
        rr_en = 1'b1;
        tick();
        chk_g("rr_after_rst", 7);
        req = '0;
        tick();

        // idle stretch, then mode toggle mid-grant
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_idle("idle", 1'b0);
        end
        rr_en = 1'b0;
        req   = 8'h06;
        tick();
        chk_g("tog0", 2);
        rr_en = 1'b1;
        req   = 8'h07;
        tick();
        chk_g("tog1", 2);
        rr_en = 1'b0;
        tick();
        chk_g("tog2", 2);
        req = 8'h01;
        tick();
        chk_idle("tog_gap", 1'b0);
        tick();
        chk_g("tog_next", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
